// File: rtl/apb_regs_slave_if.sv
// APB bus bundle between a requester and the register bank.
// Signal suffixes follow the completer's point of view.
interface apb_regs_slave_if;
  logic [31:0] paddr_i;
  logic [2:0]  pprot_i;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  modport master (
    output paddr_i, pprot_i, psel_i, penable_i,
    output pwrite_i, pwdata_i, pstrb_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  paddr_i, pprot_i, psel_i, penable_i,
    input  pwrite_i, pwdata_i, pstrb_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_regs_slave.sv
// APB completer serving a bank of 32-bit registers with
// fixed wait states, byte strobes and read-only slots.
module apb_regs_slave #(
  parameter int unsigned        NoRegs     = 4,
  parameter logic [31:0]        BaseAddr   = 32'h0,
  parameter int unsigned        WaitCycles = 0,
  parameter logic [NoRegs-1:0]  ReadOnly   = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  apb_regs_slave_if.slave          apb,
  output logic [32*NoRegs-1:0]     reg_q_o,
  input  logic [32*NoRegs-1:0]     reg_ro_i,
  output logic [NoRegs-1:0]        reg_wr_o
);

  localparam int unsigned IdxW =
    (NoRegs > 1) ? $clog2(NoRegs) : 1;
  localparam logic [31:0] Span = 32'(4 * NoRegs);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [NoRegs-1:0][31:0]  regs_q;
  logic [NoRegs-1:0]        wr_q;

  logic [31:0]              off;
  logic [IdxW-1:0]          idx;
  logic                     hit;
  logic                     sel_ro;
  logic [31:0]              sel_rd;
  logic                     err;
  logic                     commit;
  logic                     unused_prot;

  assign unused_prot = ^apb.pprot_i;

  assign off = apb.paddr_i - BaseAddr;
  assign idx = off[IdxW+1:2];
  assign hit = (apb.paddr_i >= BaseAddr) &&
               (off < Span) &&
               (apb.paddr_i[1:0] == 2'b00);

  // Select the addressed slot and its read source.
  always_comb begin
    sel_ro = 1'b0;
    sel_rd = '0;
    for (int i = 0; i < NoRegs; i++) begin
      if (idx == IdxW'(i)) begin
        sel_ro = ReadOnly[i];
        sel_rd = ReadOnly[i] ? reg_ro_i[32*i +: 32]
                             : regs_q[i];
      end
    end
  end

  assign err = !hit || (apb.pwrite_i && sel_ro);

  // State and wait counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and APB response; silent while in reset.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    apb.pready_o  = 1'b0;
    apb.pslverr_o = 1'b0;
    apb.prdata_o  = '0;
    commit        = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        IDLE: begin
          if (apb.psel_i && !apb.penable_i) begin
            state_d = ACCESS;
            cnt_d   = 4'(WaitCycles);
          end else if (apb.psel_i && apb.penable_i) begin
            apb.pready_o  = 1'b1;
            apb.pslverr_o = 1'b1;
          end
        end
        ACCESS: begin
          if (!apb.psel_i) begin
            state_d = IDLE;
          end else if (apb.penable_i) begin
            if (cnt_q != 4'd0) begin
              cnt_d = cnt_q - 4'd1;
            end else begin
              apb.pready_o  = 1'b1;
              apb.pslverr_o = err;
              if (!err && !apb.pwrite_i) begin
                apb.prdata_o = sel_rd;
              end
              commit  = !err && apb.pwrite_i;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Byte-strobed register update and write pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      regs_q <= '0;
      wr_q   <= '0;
    end else begin
      wr_q <= '0;
      if (commit) begin
        for (int i = 0; i < NoRegs; i++) begin
          if (idx == IdxW'(i) && !ReadOnly[i]) begin
            wr_q[i] <= 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (apb.pstrb_i[b]) begin
                regs_q[i][8*b +: 8] <=
                  apb.pwdata_i[8*b +: 8];
              end
            end
          end
        end
      end
    end
  end

  assign reg_q_o  = regs_q;
  assign reg_wr_o = wr_q;

endmodule

// File: tb/tb_apb_regs_slave.sv
// Directed bench for apb_regs_slave: a zero-wait bank with a
// read-only slot and a three-wait-state bank on one bus.
module tb_apb_regs_slave;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        dsel = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;

  apb_regs_slave_if ifa ();
  apb_regs_slave_if ifb ();

  assign ifa.paddr_i   = paddr;
  assign ifa.pprot_i   = 3'b000;
  assign ifa.psel_i    = psel & ~dsel;
  assign ifa.penable_i = penable;
  assign ifa.pwrite_i  = pwrite;
  assign ifa.pwdata_i  = pwdata;
  assign ifa.pstrb_i   = pstrb;
  assign ifb.paddr_i   = paddr;
  assign ifb.pprot_i   = 3'b000;
  assign ifb.psel_i    = psel & dsel;
  assign ifb.penable_i = penable;
  assign ifb.pwrite_i  = pwrite;
  assign ifb.pwdata_i  = pwdata;
  assign ifb.pstrb_i   = pstrb;

  logic [127:0] q_a, q_b;
  logic [3:0]   wr_a, wr_b;
  logic [127:0] ro_a = {32'h12345678, {3{32'hFFFFFFFF}}};
  logic [127:0] ro_b = {4{32'hA5A5A5A5}};

  apb_regs_slave #(
    .NoRegs(4), .BaseAddr(32'h0000_1000),
    .WaitCycles(0), .ReadOnly(4'b1000)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .apb(ifa),
    .reg_q_o(q_a), .reg_ro_i(ro_a), .reg_wr_o(wr_a)
  );

  apb_regs_slave #(
    .NoRegs(4), .BaseAddr(32'h0000_2000),
    .WaitCycles(3), .ReadOnly(4'b0000)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .apb(ifb),
    .reg_q_o(q_b), .reg_ro_i(ro_b), .reg_wr_o(wr_b)
  );

  wire        rdy = dsel ? ifb.pready_o  : ifa.pready_o;
  wire        slv = dsel ? ifb.pslverr_o : ifa.pslverr_o;
  wire [31:0] prd = dsel ? ifb.prdata_o  : ifa.prdata_o;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Starts #1 after a rising edge; returns #1 after the edge
  // that ends the completion cycle.
  task automatic xfer(input logic d, input logic w,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [3:0] st,
                      output logic [31:0] rd,
                      output logic er, output int n);
    dsel = d; paddr = a; pwrite = w;
    pwdata = wd; pstrb = st;
    psel = 1'b1; penable = 1'b0;
    rd = 'x; er = 1'bx; n = 1;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 2;
    forever begin
      @(negedge clk);
      if (rdy) begin
        rd = prd; er = slv;
        break;
      end
      if (n >= 20) begin
        n = 99;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          n;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q_a", q_a[31:0] | q_a[63:32] | q_a[95:64] | q_a[127:96], 32'h0);
    chk("rst_wr_a", {28'h0, wr_a}, 32'h0);
    chk("rst_rdy_a", {31'h0, ifa.pready_o}, 32'h0);
    chk("rst_err_a", {31'h0, ifa.pslverr_o}, 32'h0);
    chk("rst_prd_a", ifa.prdata_o, 32'h0);
    chk("rst_q_b", q_b[31:0] | q_b[63:32] | q_b[95:64] | q_b[127:96], 32'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_rdy_a", {31'h0, ifa.pready_o}, 32'h0);
    @(posedge clk); #1;

    xfer(0, 1, 32'h1004, 32'hDEADBEEF, 4'hF, rd, er, n);
    chk("w1_len", n, 2);
    chk("w1_err", {31'h0, er}, 32'h0);
    chk("w1_q", q_a[63:32], 32'hDEADBEEF);
    chk("w1_wr", {28'h0, wr_a}, 32'h2);
    @(posedge clk); #1;
    chk("w1_wr_off", {28'h0, wr_a}, 32'h0);
    xfer(0, 0, 32'h1004, 32'h0, 4'h0, rd, er, n);
    chk("r1_data", rd, 32'hDEADBEEF);
    chk("r1_err", {31'h0, er}, 32'h0);
    chk("r1_len", n, 2);

    xfer(0, 1, 32'h1008, 32'h11223344, 4'hF, rd, er, n);
    xfer(0, 0, 32'h1008, 32'h0, 4'h0, rd, er, n);
    chk("raw_data", rd, 32'h11223344);

    xfer(0, 1, 32'h1000, 32'hAABBCCDD, 4'b0101, rd, er, n);
    chk("strb_q", q_a[31:0], 32'h00BB00DD);
    chk("strb_wr", {28'h0, wr_a}, 32'h1);
    xfer(0, 1, 32'h1000, 32'hFFFFFFFF, 4'b0000, rd, er, n);
    chk("strb0_q", q_a[31:0], 32'h00BB00DD);
    chk("strb0_wr", {28'h0, wr_a}, 32'h1);

    xfer(0, 1, 32'h100C, 32'hFFFFFFFF, 4'hF, rd, er, n);
    chk("ro_w_err", {31'h0, er}, 32'h1);
    chk("ro_w_wr", {28'h0, wr_a}, 32'h0);
    chk("ro_w_q", q_a[127:96], 32'h0);
    xfer(0, 0, 32'h100C, 32'h0, 4'h0, rd, er, n);
    chk("ro_r_data", rd, 32'h12345678);
    chk("ro_r_err", {31'h0, er}, 32'h0);
    xfer(0, 0, 32'h1010, 32'h0, 4'h0, rd, er, n);
    chk("oor_err", {31'h0, er}, 32'h1);
    chk("oor_data", rd, 32'h0);
    xfer(0, 0, 32'h1002, 32'h0, 4'h0, rd, er, n);
    chk("mis_err", {31'h0, er}, 32'h1);
    chk("mis_data", rd, 32'h0);
    xfer(0, 0, 32'h0FFC, 32'h0, 4'h0, rd, er, n);
    chk("below_err", {31'h0, er}, 32'h1);

    xfer(1, 0, 32'h2004, 32'h0, 4'h0, rd, er, n);
    chk("b_r0_len", n, 5);
    chk("b_r0_data", rd, 32'h0);
    chk("b_r0_err", {31'h0, er}, 32'h0);
    xfer(1, 1, 32'h2004, 32'h0000CAFE, 4'hF, rd, er, n);
    chk("b_w_len", n, 5);
    chk("b_w_q", q_b[63:32], 32'h0000CAFE);
    chk("b_w_wr", {28'h0, wr_b}, 32'h2);
    xfer(1, 0, 32'h2004, 32'h0, 4'h0, rd, er, n);
    chk("b_r1_data", rd, 32'h0000CAFE);

    dsel = 1'b1; paddr = 32'h2000; pwrite = 1'b1;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("ab_wait_rdy", {31'h0, rdy}, 32'h0);
    chk("ab_wait_prd", prd, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("ab_rdy", {31'h0, rdy}, 32'h0);
    @(posedge clk); #1;
    chk("ab_wr", {28'h0, wr_b}, 32'h0);
    chk("ab_q", q_b[31:0], 32'h0);
    xfer(1, 1, 32'h2000, 32'h00000077, 4'hF, rd, er, n);
    chk("ab_next_len", n, 5);
    chk("ab_next_q", q_b[31:0], 32'h00000077);

    dsel = 1'b1; paddr = 32'h2008; pwrite = 1'b1;
    pwdata = 32'h00000055; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(negedge clk);
    chk("rstm_rdy", {31'h0, rdy}, 32'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    psel = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rstm_wr", {28'h0, wr_b}, 32'h0);
    end
    chk("rstm_q2", q_b[95:64], 32'h0);
    chk("rstm_q0", q_b[31:0], 32'h0);

    dsel = 1'b1; paddr = 32'h2000; pwrite = 1'b1;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b1;
    @(negedge clk);
    chk("viol_rdy", {31'h0, rdy}, 32'h1);
    chk("viol_err", {31'h0, slv}, 32'h1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    chk("viol_wr", {28'h0, wr_b}, 32'h0);
    @(posedge clk); #1;
    chk("viol_q", q_b[31:0], 32'h0);
    xfer(1, 0, 32'h200C, 32'h0, 4'h0, rd, er, n);
    chk("viol_next_len", n, 5);
    chk("viol_next_err", {31'h0, er}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_regs_slave.md
# apb_regs_slave

Target-side (completer) APB register bank: accepts APB transfers driven through the `APB` interface's `in`/`Slave` end and serves `NoRegs` 32-bit registers at word-aligned addresses from `BaseAddr`. It inserts a fixed number of wait states, applies byte strobes and flags errors with `pslverr`. Register contents go to the surrounding logic; read-only slots read values supplied by that logic. It sits behind an APB demux/bridge as a generic control/status peripheral.

## Interface
- `NoRegs`, default 4: number of 32-bit registers, 1..64.
- `BaseAddr`, default 32'h0: byte address of register 0, 4-byte aligned.
- `WaitCycles`, default 0: wait states inserted in the access phase, 0..15.
- `ReadOnly`, default '0: `NoRegs`-bit mask; bit i=1 makes register i read-only.
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `paddr_i`  in  32  APB address.
- `pprot_i`  in  3  protection; ignored.
- `psel_i`  in  1  select.
- `penable_i`  in  1  enable (access phase).
- `pwrite_i`  in  1  1 = write.
- `pwdata_i`  in  32  write data.
- `pstrb_i`  in  4  byte strobes; bit b covers `pwdata_i[8b+7:8b]`.
- `prdata_o`  out  32  read data.
- `pready_o`  out  1  transfer completes this cycle.
- `pslverr_o`  out  1  transfer error, valid with `pready_o`.
- `reg_q_o`  out  32*NoRegs  register contents; register i at `[32i+31:32i]`.
- `reg_ro_i`  in  32*NoRegs  read value for read-only registers, same packing.
- `reg_wr_o`  out  NoRegs  one-cycle pulse: register i was written.

## Operation
- Decode: `off = paddr_i - BaseAddr`, `idx = off[31:2]`. Hit when `paddr_i >= BaseAddr`, `off < 4*NoRegs` and `paddr_i[1:0] == 0`.
- Error when there is no hit, or on a write to a register with `ReadOnly[idx]=1`. An error transfer completes normally with `pslverr_o=1`, has no register side effect and returns `prdata_o=0`.
- FSM states are IDLE and ACCESS. A 4-bit counter `cnt` tracks wait states.
- IDLE:
  - `psel_i & !penable_i` (setup phase) -> ACCESS, `cnt <= WaitCycles`.
  - `psel_i & penable_i` without a prior setup is a protocol violation. Respond the same cycle with `pready_o=1`, `pslverr_o=1`, no write. Stay in IDLE.
- ACCESS:
  - `!psel_i` aborts the transfer -> IDLE. No write, no response.
  - `psel_i & penable_i & cnt != 0`: `pready_o=0`, decrement `cnt`.
  - `psel_i & penable_i & cnt == 0` is the completion cycle: `pready_o=1`, `pslverr_o` per decode, commit, -> IDLE.
- Write commit: for each byte b with `pstrb_i[b]=1`, set `reg[idx][8b+7:8b] <= pwdata_i[8b+7:8b]`. Set `reg_wr_o[idx] <= 1` for one cycle, even when `pstrb_i=0`.
- Read in the completion cycle:
  - `prdata_o` = `reg_ro_i` slice if `ReadOnly[idx]`, else `reg[idx]`.
  - `prdata_o` = 0 in every other cycle.
- Address, data and direction are sampled in the completion cycle. Their stability across the transfer is the master's obligation.
- Bits of read-only registers are never written. Their `reg_q_o` slice stays 0.

## Timing
- Reset (`rst_ni=0` at a clock edge): state IDLE, `cnt=0`, all registers 0.
- Outputs during and after reset: `reg_q_o=0`, `reg_wr_o=0`, `pready_o=0`, `pslverr_o=0`, `prdata_o=0`.
- Reset asserted mid-transfer abandons the transfer. No write, no response.
- `pready_o`, `pslverr_o` and `prdata_o` are combinational from state, `cnt` and the APB inputs. They are asserted only in the completion cycle (or the violation cycle).
- Transfer length is `2 + WaitCycles` cycles (setup + access). `WaitCycles=0` gives the standard zero-wait APB transfer.
- `reg_q_o` and `reg_wr_o` update on the clock edge ending the completion cycle, so they are visible 1 cycle later.
- Back-to-back: a setup phase in the cycle right after completion is accepted, giving a new transfer every `2 + WaitCycles` cycles.
- A read of register i in the cycle after a write to it returns the new value.

## Test plan
- Reset, then check outputs → all zero. Check `pready_o=0` while idle.
- `WaitCycles=0`: write 32'hDEADBEEF to `BaseAddr+4` with `pstrb=4'hF`.
  - → `pready_o=1` in the 2nd cycle, `pslverr_o=0`.
  - → next cycle `reg_q_o[63:32]=32'hDEADBEEF`, `reg_wr_o=4'b0010` for 1 cycle.
  - Then read `BaseAddr+4` → `prdata_o=32'hDEADBEEF`.
- Strobes: with reg0=32'h0, write 32'hAABBCCDD with `pstrb=4'b0101` → reg0=32'h00BB00DD.
- `WaitCycles=3`: read → `pready_o` low for exactly 3 access cycles, high on the 4th. Total 5 cycles.
- Errors with `ReadOnly=4'b1000`:
  - Write to `BaseAddr+12` → `pslverr_o=1`, no `reg_wr_o`.
  - Read `BaseAddr+12` with `reg_ro_i` slice 32'h12345678 → `prdata_o=32'h12345678`.
  - Access `BaseAddr+16` → `pslverr_o=1`, `prdata_o=0`.
  - Access `BaseAddr+2` → `pslverr_o=1`, `prdata_o=0`.
- Boundary cases (with `WaitCycles=3`):
  - Drop `psel_i` during a wait state → no write, FSM back to IDLE, next transfer OK.
  - Assert `rst_ni=0` mid-write → register stays 0.
  - Access phase without setup → immediate `pready_o=1`, `pslverr_o=1`.
